// File: rtl/mmp_pkg.sv
// Shared MMP sound-path definitions: ID width, arbiter state encoding, logic constants
// and the round-robin wrap helper.
package mmp_pkg;

   localparam int unsigned MMP_ID_W = 2;

   localparam logic HIGH = 1'b1;
   localparam logic LOW  = 1'b0;

   typedef enum logic [1:0] {IDLE, SEND, GUARD_W} state_e;

   // (base + off) mod n, truncated to an ID
   function automatic logic [MMP_ID_W-1:0] rr_wrap(input logic [MMP_ID_W-1:0] base,
                                                   input int unsigned off,
                                                   input int unsigned n);
      int unsigned v_sum;
      v_sum = (32'(base) + off) % n;
      return MMP_ID_W'(v_sum);
   endfunction

endpackage

// File: rtl/mmp_rr_pick.sv
// Combinational rotate-priority encoder: first set request after last_gnt, with wrap-around.
module mmp_rr_pick
   import mmp_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic [MMP_ID_W-1:0] i_last_gnt,
   output logic [NUM_REQ-1:0]  o_onehot,
   output logic [MMP_ID_W-1:0] o_idx,
   output logic                o_any
);

   always_comb begin
      logic [MMP_ID_W-1:0] v_c;
      o_onehot = '0;
      o_idx    = '0;
      o_any    = LOW;
      v_c      = '0;
      // Scan farthest offset first so the nearest set request wins.
      for (int unsigned i = NUM_REQ; i > 0; i--) begin
         v_c = rr_wrap(i_last_gnt, i, NUM_REQ);
         if (i_req[v_c]) begin
            o_onehot      = '0;
            o_onehot[v_c] = HIGH;
            o_idx         = v_c;
            o_any         = HIGH;
         end
      end
   end

endmodule

// File: rtl/mmp_cdc_arbiter.sv
// Round-robin arbiter sharing one valid/ack CDC word link among NUM_REQ sample producers,
// with a post-transfer guard gap and ack timeout with saturating drop count.
module mmp_cdc_arbiter
   import mmp_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned GUARD       = 2,
   parameter int unsigned ACK_TIMEOUT = 63
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic [NUM_REQ-1:0]        i_REQ,
   input  logic [NUM_REQ*DATA_W-1:0] i_DATA,
   output logic [NUM_REQ-1:0]        o_GNT,
   output logic                      o_XFER_VALID,
   output logic signed [DATA_W-1:0]  o_XFER_DATA,
   output logic [MMP_ID_W-1:0]       o_XFER_ID,
   input  logic                      i_XFER_ACK,
   output logic                      o_BUSY,
   output logic                      o_TIMEOUT,
   output logic [7:0]                o_DROP_CNT
);

   localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);
   localparam int unsigned GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;

   state_e              r_state,     w_state_d;
   logic [TMO_W-1:0]    r_tmo_cnt,   w_tmo_cnt_d;
   logic [GRD_W-1:0]    r_grd_cnt,   w_grd_cnt_d;
   logic [MMP_ID_W-1:0] r_last_gnt,  w_last_gnt_d;
   logic [NUM_REQ-1:0]  r_gnt,       w_gnt_d;
   logic                r_valid,     w_valid_d;
   logic [DATA_W-1:0]   r_data,      w_data_d;
   logic [MMP_ID_W-1:0] r_id,        w_id_d;
   logic                r_busy,      w_busy_d;
   logic                r_timeout,   w_timeout_d;
   logic [7:0]          r_drop_cnt,  w_drop_cnt_d;

   logic [NUM_REQ-1:0]  w_pick_onehot;
   logic [MMP_ID_W-1:0] w_pick_idx;
   logic                w_pick_any;

   mmp_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req      (i_REQ),
      .i_last_gnt (r_last_gnt),
      .o_onehot   (w_pick_onehot),
      .o_idx      (w_pick_idx),
      .o_any      (w_pick_any)
   );

   always_comb begin
      w_state_d    = r_state;
      w_tmo_cnt_d  = r_tmo_cnt;
      w_grd_cnt_d  = r_grd_cnt;
      w_last_gnt_d = r_last_gnt;
      w_gnt_d      = '0;
      w_valid_d    = r_valid;
      w_data_d     = r_data;
      w_id_d       = r_id;
      w_timeout_d  = LOW;
      w_drop_cnt_d = r_drop_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_gnt_d      = w_pick_onehot;
               w_valid_d    = HIGH;
               w_data_d     = i_DATA[w_pick_idx*DATA_W +: DATA_W];
               w_id_d       = w_pick_idx;
               w_last_gnt_d = w_pick_idx;
               w_tmo_cnt_d  = '0;
               w_state_d    = SEND;
            end
         end
         SEND: begin
            // Ack takes precedence over a timeout landing on the same cycle.
            if (i_XFER_ACK) begin
               w_valid_d   = LOW;
               w_grd_cnt_d = '0;
               w_state_d   = GUARD_W;
            end else if (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
               w_valid_d   = LOW;
               w_timeout_d = HIGH;
               w_grd_cnt_d = '0;
               w_state_d   = GUARD_W;
               if (r_drop_cnt != 8'hFF) w_drop_cnt_d = r_drop_cnt + 8'd1;
            end else begin
               w_tmo_cnt_d = r_tmo_cnt + TMO_W'(1);
            end
         end
         GUARD_W: begin
            if (r_grd_cnt == GRD_W'(GUARD - 1)) w_state_d = IDLE;
            else                                w_grd_cnt_d = r_grd_cnt + GRD_W'(1);
         end
         default: w_state_d = IDLE;
      endcase
      w_busy_d = (w_state_d != IDLE);
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         r_state    <= IDLE;
         r_tmo_cnt  <= '0;
         r_grd_cnt  <= '0;
         r_last_gnt <= MMP_ID_W'(NUM_REQ - 1);
         r_gnt      <= '0;
         r_valid    <= LOW;
         r_data     <= '0;
         r_id       <= '0;
         r_busy     <= LOW;
         r_timeout  <= LOW;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_tmo_cnt  <= w_tmo_cnt_d;
         r_grd_cnt  <= w_grd_cnt_d;
         r_last_gnt <= w_last_gnt_d;
         r_gnt      <= w_gnt_d;
         r_valid    <= w_valid_d;
         r_data     <= w_data_d;
         r_id       <= w_id_d;
         r_busy     <= w_busy_d;
         r_timeout  <= w_timeout_d;
         r_drop_cnt <= w_drop_cnt_d;
      end
   end

   assign o_GNT        = r_gnt;
   assign o_XFER_VALID = r_valid;
   assign o_XFER_DATA  = r_data;
   assign o_XFER_ID    = r_id;
   assign o_BUSY       = r_busy;
   assign o_TIMEOUT    = r_timeout;
   assign o_DROP_CNT   = r_drop_cnt;

endmodule

// File: tb/tb_mmp_cdc_arbiter.sv
// Scoreboard bench for mmp_cdc_arbiter: expected grants queued by stimulus, checked by monitor.
module tb_mmp_cdc_arbiter;

   typedef struct {
      logic [1:0]  id;
      logic [15:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [63:0] din;
   logic [3:0]  gnt;
   logic        valid;
   logic [15:0] xdata;
   logic [1:0]  xid;
   logic        ack;
   logic        busy;
   logic        tmo;
   logic [7:0]  drop;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   prev_g  = -1;
   int   vcyc;
   int   exp_drop;
   bit   ok;

   mmp_cdc_arbiter #(
      .NUM_REQ     (4),
      .DATA_W      (16),
      .GUARD       (2),
      .ACK_TIMEOUT (63)
   ) dut (
      .i_CLK        (clk),
      .i_RST        (rst),
      .i_REQ        (req),
      .i_DATA       (din),
      .o_GNT        (gnt),
      .o_XFER_VALID (valid),
      .o_XFER_DATA  (xdata),
      .o_XFER_ID    (xid),
      .i_XFER_ACK   (ack),
      .o_BUSY       (busy),
      .o_TIMEOUT    (tmo),
      .o_DROP_CNT   (drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [15:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic bound_fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event within bound, required event", name);
   endtask

   task automatic wait_valid(output bit found);
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (valid) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!found) bound_fail("valid_wait");
   endtask

   task automatic wait_timeout(output bit found);
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tmo) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) bound_fail("timeout_wait");
   endtask

   // Wait for a word, ack it on the following edge, optionally check grant spacing.
   task automatic serve_one(input bit chk_space);
      bit f;
      wait_valid(f);
      if (chk_space && prev_g >= 0) check("grant_spacing", cyc - prev_g, 4);
      prev_g = cyc;
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("valid_fall_on_ack", {31'd0, valid}, 0);
      check("gnt_one_cycle", {28'd0, gnt}, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && gnt != 4'd0) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_grant: got gnt=%b, required no grant", gnt);
         end else begin
            mon_e = q.pop_front();
            check("gnt_onehot", {28'd0, gnt}, {28'd0, 4'b0001 << mon_e.id});
            check("xfer_id", {30'd0, xid}, {30'd0, mon_e.id});
            check("xfer_data", {16'd0, xdata}, {16'd0, mon_e.data});
            check("valid_at_gnt", {31'd0, valid}, 1);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req = 4'd0;
      ack = 1'b0;
      din = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      repeat (3) @(negedge clk);
      check("rst_ctl", {24'd0, gnt, valid, xid, busy, tmo}, 0);
      check("rst_data", {8'd0, xdata, drop}, 0);

      // First grant, then an asynchronous reset in the middle of SEND
      push(2'd0, 16'h1000);
      rst = 1'b0;
      req = 4'b1111;
      wait_valid(ok);
      check("busy_in_send", {31'd0, busy}, 1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_ctl", {24'd0, gnt, valid, xid, busy, tmo}, 0);
      check("rst_mid_data", {8'd0, xdata, drop}, 0);

      // Round robin after reset: 0,1,2,3,0 spaced 4 cycles
      @(negedge clk);
      push(2'd0, 16'h1000);
      push(2'd1, 16'h1001);
      push(2'd2, 16'h1002);
      push(2'd3, 16'h1003);
      push(2'd0, 16'h1000);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) serve_one(1'b1);
      req = 4'd0;

      // Data latch: lane 2 captured and held while the input moves
      repeat (4) @(negedge clk);
      din[32 +: 16] = 16'h8001;
      push(2'd2, 16'h8001);
      req = 4'b0100;
      wait_valid(ok);
      req = 4'd0;
      din[32 +: 16] = 16'h1234;
      repeat (3) @(negedge clk);
      check("data_hold", {16'd0, xdata}, 32'h8001);
      check("id_hold", {30'd0, xid}, 2);
      check("valid_hold", {31'd0, valid}, 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("data_after_valid", {16'd0, xdata}, 32'h8001);

      // Spurious ack in IDLE
      repeat (4) @(negedge clk);
      check("idle_busy", {31'd0, busy}, 0);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("spur_ack_ctl", {24'd0, gnt, valid, xid, busy, tmo}, {24'd0, 4'd0, 1'b0, 2'd2, 1'b0, 1'b0});
      @(negedge clk);
      check("spur_ack_busy", {31'd0, busy}, 0);

      // Skip/wrap from last_gnt=2 with requests 0 and 1 only
      prev_g = -1;
      push(2'd0, 16'h1000);
      push(2'd1, 16'h1001);
      req = 4'b0011;
      serve_one(1'b1);
      serve_one(1'b1);
      req = 4'd0;

      // Timeout: no ack, drop after 63 cycles
      repeat (4) @(negedge clk);
      push(2'd0, 16'h1000);
      req = 4'b0001;
      wait_valid(ok);
      req = 4'd0;
      vcyc = cyc;
      wait_timeout(ok);
      check("timeout_latency", cyc - vcyc, 63);
      check("valid_fall_on_tmo", {31'd0, valid}, 0);
      check("drop_cnt_1", {24'd0, drop}, 1);
      @(negedge clk);
      check("timeout_pulse_width", {31'd0, tmo}, 0);

      // Ack on the timeout cycle wins
      repeat (4) @(negedge clk);
      push(2'd0, 16'h1000);
      req = 4'b0001;
      wait_valid(ok);
      req = 4'd0;
      vcyc = cyc;
      while (cyc < vcyc + 62) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("ack_tmo_valid", {31'd0, valid}, 0);
      check("ack_tmo_no_pulse", {31'd0, tmo}, 0);
      check("ack_tmo_drop", {24'd0, drop}, 1);
      @(negedge clk);
      check("ack_tmo_no_pulse2", {31'd0, tmo}, 0);

      // Drop counter saturation: 259 more drops
      repeat (4) @(negedge clk);
      exp_drop = 1;
      for (int i = 0; i < 259; i++) push(2'd0, 16'h1000);
      req = 4'b0001;
      for (int i = 0; i < 259; i++) begin
         wait_timeout(ok);
         if (!ok) break;
         exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
         check("drop_cnt", {24'd0, drop}, exp_drop);
      end
      req = 4'd0;
      repeat (6) @(negedge clk);
      check("drop_cnt_sat", {24'd0, drop}, 255);
      check("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmp_cdc_arbiter.md
# mmp_cdc_arbiter

Single-clock round-robin arbiter that shares one CDC word-transfer link among up to four signed 16-bit sample producers in the MMP sound path. It grants one requester at a time and holds the word, with a channel ID, on the link's valid/ack handshake. It enforces a guard gap between words and drops a word whose ack never arrives. It sits in the source clock domain, in front of the F2L-style transfer channel.

## Interface
- NUM_REQ, 4, number of requesters (2..4); ID width is 2
- DATA_W, 16, sample width, signed
- GUARD, 2, idle cycles with o_XFER_VALID low after each transfer (≥1)
- ACK_TIMEOUT, 63, cycles in SEND without ack before drop (≥4)

Ports:
- i_CLK  in  1  sole clock
- i_RST  in  1  reset, asynchronous, active-high
- i_REQ  in  NUM_REQ  per-requester level request; held until granted
- i_DATA  in  NUM_REQ*DATA_W  packed samples; requester k occupies bits [k*DATA_W +: DATA_W]
- o_GNT  out  NUM_REQ  one-hot, one-cycle pulse; the word is captured on this cycle
- o_XFER_VALID  out  1  word valid toward the link
- o_XFER_DATA  out  DATA_W  latched sample, stable while valid
- o_XFER_ID  out  2  index of the granted requester
- i_XFER_ACK  in  1  ack pulse from the link, already synchronized to i_CLK
- o_BUSY  out  1  high in any state other than IDLE
- o_TIMEOUT  out  1  one-cycle pulse when a word is dropped
- o_DROP_CNT  out  8  saturating count of dropped words

## Operation
- FSM states: IDLE, SEND, GUARD_W.
- IDLE, any i_REQ bit set:
  - pick the first set bit scanning from (last_gnt+1) mod NUM_REQ upward, with wrap-around
  - register the one-hot o_GNT pulse and latch the data and ID
  - assert o_XFER_VALID, update last_gnt, go to SEND
- SEND:
  - o_XFER_VALID, data and ID hold
  - i_XFER_ACK high: deassert valid, go to GUARD_W
  - otherwise tmo_cnt increments; when tmo_cnt reaches ACK_TIMEOUT-1 with no ack: pulse o_TIMEOUT, increment o_DROP_CNT (saturates at 255), deassert valid, go to GUARD_W
- GUARD_W: valid low for GUARD cycles (counter), then IDLE.
- Ack and timeout in the same cycle: the ack wins. No o_TIMEOUT pulse, no count increment.
- i_XFER_ACK in IDLE or GUARD_W is ignored.
- A requester that drops i_REQ before its grant is skipped without error.
- o_XFER_DATA keeps the last word after valid falls. It changes only at a grant.
- Reset, asynchronous and any time including mid-SEND:
  - state = IDLE; tmo_cnt and guard counter = 0
  - every output = 0, including o_XFER_DATA and o_DROP_CNT
  - last_gnt = NUM_REQ-1, so requester 0 has first priority

## Timing
- Grant latency: i_REQ seen in IDLE at edge n gives o_GNT, o_XFER_VALID, data and ID all valid after edge n (registered, 1 cycle).
- Ack sampled at edge m gives valid low after edge m. The next grant comes no earlier than edge m+GUARD+1.
- Timeout: valid falls ACK_TIMEOUT cycles after it rose, when no ack arrived.
- Maximum throughput: one word per 2+GUARD cycles when acks arrive immediately.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package mmp_pkg holds:
  - localparam MMP_ID_W = 2
  - the state enum {IDLE, SEND, GUARD_W}
  - the `HIGH`/`LOW` constants already used across MMP
- One sub-module: mmp_rr_pick. It is a combinational rotate-priority-encoder with inputs (req, last_gnt) and outputs (onehot, idx, any).
- The FSM, counters and datapath latch live in the top level.

## Test plan
- Reset: hold i_RST high mid-SEND → all outputs 0 in the same cycle; after release, i_REQ=4'b1111 → o_GNT=4'b0001, o_XFER_ID=0.
- Round robin: i_REQ=4'b1111 held, ack 1 cycle after each valid → IDs 0,1,2,3,0. Grants are spaced exactly 2+GUARD=4 cycles apart.
- Skip/wrap: last_gnt=2, i_REQ=4'b0011 → grant ID 0, then ID 1. Requester 3 is never granted.
- Data: i_DATA lane 2 = 16'sh8001 at grant → o_XFER_DATA=16'sh8001, ID=2. The value stays stable while lane 2 input changes during SEND.
- Timeout: no ack → o_TIMEOUT pulses 63 cycles after valid rose, o_DROP_CNT 0→1. Forcing 260 drops → o_DROP_CNT stops at 255.
- Simultaneous ack on the timeout cycle → no o_TIMEOUT and o_DROP_CNT unchanged. A spurious ack in IDLE → no state change.
